fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 SHALL have parameter DEPTH, default 4, meaning the fetch-buffer entry count; legal values are powers of two from 2 to 16.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-low reset (0 = reset).
REQ-005 SHALL have port imem_req_valid, output, 1 bit: fetch request valid.
REQ-006 SHALL have port imem_req_addr, output, 32 bits: fetch address, word aligned.
REQ-007 SHALL have port imem_req_ready, input, 1 bit: memory accepts the request this cycle.
REQ-008 SHALL have port imem_resp_valid, input, 1 bit: instruction word returned this cycle.
REQ-009 SHALL have port imem_resp_data, input, 32 bits: the returned instruction.
REQ-010 SHALL have port stall, input, 1 bit: hazard unit holds the IF/ID register.
REQ-011 SHALL have port redirect, input, 1 bit: branch taken in ID; flush and refetch.
REQ-012 SHALL have port redirect_pc, input, 32 bits: branch target address.
REQ-013 SHALL have port if_valid, output, 1 bit: if_instruction is valid for IF/ID.
REQ-014 SHALL have port if_instruction, output, 32 bits: head-entry instruction.
REQ-015 SHALL have port if_pc_plus4, output, 32 bits: head-entry PC + 4.

Function
REQ-016 SHALL hold a fetch_pc register; imem_req_addr = fetch_pc.
REQ-017 SHALL keep a DEPTH-entry circular buffer with three pointers:
- alloc_ptr: advances on request handshake; the entry stores the PC and an empty flag.
- fill_ptr: advances on accepted response; writes imem_resp_data and sets the entry full.
- read_ptr: advances on dequeue.
REQ-018 SHALL assert imem_req_valid when (count + drop_cnt) < DEPTH and redirect = 0; count = allocated entries, 0..DEPTH.
REQ-019 SHALL treat a request as accepted when imem_req_valid && imem_req_ready; fetch_pc <= fetch_pc + 4 (mod 2^32, wraps from FFFF_FFFC to 0).
REQ-020 SHALL assume in-order responses, exactly one per accepted request, arriving no earlier than the cycle after acceptance.
REQ-021 SHALL drive if_valid = 1 when the read_ptr entry is full.
REQ-022 SHALL drive if_instruction and if_pc_plus4 from the read_ptr entry; both are don't-care when if_valid = 0.
REQ-023 SHALL dequeue when if_valid && !stall && !redirect.
REQ-024 SHALL allow request, response and dequeue in the same cycle; count = count + req_acc - deq.
REQ-025 SHALL handle redirect = 1 as follows (redirect has priority over stall, request and dequeue):
- all entries invalidated; pointers and count reset to 0;
- fetch_pc <= redirect_pc;
- drop_cnt <= responses still outstanding (allocated but not filled), excluding any response arriving this cycle.
REQ-026 SHALL discard a response arriving in the redirect cycle.
REQ-027 SHALL discard a response arriving while drop_cnt > 0 and decrement drop_cnt; it never writes the buffer.
REQ-028 SHALL allow new requests after a redirect while drop_cnt > 0, subject to REQ-018.
REQ-029 SHALL never overflow: count never exceeds DEPTH, and a response with no allocated entry never occurs under REQ-020.
REQ-030 SHALL ignore bits [1:0] of redirect_pc (forced to 0).

Reset
REQ-031 SHALL, while reset = 0 at a clock edge, set fetch_pc = RESET_PC, pointers = 0, count = 0, drop_cnt = 0 and all full flags = 0.
REQ-032 SHALL hold imem_req_valid = 0 and if_valid = 0 during reset.
REQ-033 SHALL discard responses arriving during reset and never count them as outstanding.
REQ-034 SHALL assert imem_req_valid with addr = RESET_PC in the first cycle after reset = 1.
REQ-035 SHALL, on reset mid-operation, discard all in-flight state, with no output glitch beyond REQ-032.

Verification
REQ-036 SHALL cover streaming: ready = 1, 1-cycle response latency, stall = 0 -> instructions at PCs 0, 4, 8, 12 appear on consecutive cycles with if_pc_plus4 = 4, 8, 12, 16.
REQ-037 SHALL cover buffer full: stall = 1 for 10 cycles -> exactly 4 requests issued (0..C), then imem_req_valid = 0; after stall = 0, the 4 entries drain in order and fetching resumes at 0x10.
REQ-038 SHALL cover redirect with in-flight work: 2 requests outstanding at 0x20 and 0x24, redirect to 0x100 -> if_valid = 0 the next cycle, both late responses dropped, the first delivered instruction has if_pc_plus4 = 0x104.
REQ-039 SHALL cover redirect while stalled: redirect = 1 and stall = 1 simultaneously -> flush still occurs and fetch_pc = redirect_pc.
REQ-040 SHALL cover memory backpressure: imem_req_ready = 0 for 3 cycles -> imem_req_addr is held constant and no entry is allocated.
REQ-041 SHALL cover reset mid-stream: reset = 0 with 3 entries full -> after release, if_valid = 0 and the first request addr = RESET_PC.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues word-aligned fetch requests into a circular buffer
// and presents the oldest returned instruction to the IF/ID register.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 4
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    output logic [31:0] if_instruction,
    output logic [31:0] if_pc_plus4
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [31:0]      fetch_pc_q, fetch_pc_d;
    logic [PW-1:0]    alloc_ptr_q, alloc_ptr_d;
    logic [PW-1:0]    fill_ptr_q, fill_ptr_d;
    logic [PW-1:0]    read_ptr_q, read_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [CW-1:0]    pend_q, pend_d;
    logic [CW-1:0]    drop_q, drop_d;
    logic [DEPTH-1:0] full_q, full_d;
    logic [31:0]      pc_mem    [DEPTH];
    logic [31:0]      instr_mem [DEPTH];

    logic             req_acc;
    logic             resp_fill;
    logic             resp_drop;
    logic             deq;
    logic [CW:0]      inflight;

    // Slots still owed to the memory include late responses that will be dropped.
    always_comb begin
        inflight       = {1'b0, count_q} + {1'b0, drop_q};
        imem_req_valid = reset && !redirect && (inflight < (CW+1)'(DEPTH));
        imem_req_addr  = fetch_pc_q;
        req_acc        = imem_req_valid && imem_req_ready;
        if_valid       = reset && full_q[read_ptr_q];
        if_instruction = instr_mem[read_ptr_q];
        if_pc_plus4    = pc_mem[read_ptr_q] + 32'd4;
        deq            = if_valid && !stall && !redirect;
        resp_fill      = reset && imem_resp_valid && !redirect && (drop_q == '0);
        resp_drop      = reset && imem_resp_valid && !redirect && (drop_q != '0);
    end

    always_comb begin
        fetch_pc_d  = fetch_pc_q;
        alloc_ptr_d = alloc_ptr_q;
        fill_ptr_d  = fill_ptr_q;
        read_ptr_d  = read_ptr_q;
        count_d     = count_q;
        pend_d      = pend_q;
        drop_d      = drop_q;
        full_d      = full_q;
        if (redirect) begin
            fetch_pc_d  = {redirect_pc[31:2], 2'b00};
            alloc_ptr_d = '0;
            fill_ptr_d  = '0;
            read_ptr_d  = '0;
            count_d     = '0;
            pend_d      = '0;
            full_d      = '0;
            // A response landing this cycle is discarded and no longer owed.
            drop_d      = drop_q + pend_q - CW'(imem_resp_valid);
        end else begin
            if (req_acc) begin
                fetch_pc_d           = fetch_pc_q + 32'd4;
                alloc_ptr_d          = alloc_ptr_q + PW'(1);
                full_d[alloc_ptr_q]  = 1'b0;
            end
            if (resp_drop) begin
                drop_d = drop_q - CW'(1);
            end
            if (resp_fill) begin
                full_d[fill_ptr_q] = 1'b1;
                fill_ptr_d         = fill_ptr_q + PW'(1);
            end
            if (deq) begin
                full_d[read_ptr_q] = 1'b0;
                read_ptr_d         = read_ptr_q + PW'(1);
            end
            count_d = count_q + CW'(req_acc) - CW'(deq);
            pend_d  = pend_q + CW'(req_acc) - CW'(resp_fill);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            fetch_pc_q  <= RESET_PC;
            alloc_ptr_q <= '0;
            fill_ptr_q  <= '0;
            read_ptr_q  <= '0;
            count_q     <= '0;
            pend_q      <= '0;
            drop_q      <= '0;
            full_q      <= '0;
        end else begin
            fetch_pc_q  <= fetch_pc_d;
            alloc_ptr_q <= alloc_ptr_d;
            fill_ptr_q  <= fill_ptr_d;
            read_ptr_q  <= read_ptr_d;
            count_q     <= count_d;
            pend_q      <= pend_d;
            drop_q      <= drop_d;
            full_q      <= full_d;
        end
    end

    // Payload storage needs no reset; validity lives in full_q.
    always_ff @(posedge clk) begin
        if (req_acc) begin
            pc_mem[alloc_ptr_q] <= fetch_pc_q;
        end
        if (resp_fill) begin
            instr_mem[fill_ptr_q] <= imem_resp_data;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: in-order memory model with programmable latency and a
// scoreboard of hand-computed deliveries popped whenever the unit dequeues.
module tb_fetch_unit;
    logic        clk;
    logic        reset;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic [31:0] if_instruction;
    logic [31:0] if_pc_plus4;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    mreq_t       mq[$];
    logic [63:0] exp_q[$];
    logic [63:0] mon_exp;
    mreq_t       mreq;
    int          cyc;
    int          lat;
    int          acc_cnt;
    int          acc_base;
    int          errors;
    int          checks;

    fetch_unit #(
        .RESET_PC(32'h0000_0000),
        .DEPTH   (4)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_resp_valid(imem_resp_valid),
        .imem_resp_data (imem_resp_data),
        .stall          (stall),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc),
        .if_valid       (if_valid),
        .if_instruction (if_instruction),
        .if_pc_plus4    (if_pc_plus4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] mk(input logic [31:0] a);
        return {a[15:0], 16'hC0DE};
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, got, req);
        end
    endtask

    task automatic exp_push(input logic [31:0] pc4, input logic [31:0] instr);
        exp_q.push_back({pc4, instr});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Memory: record accepted requests mid-cycle, answer in order once due.
    always @(negedge clk) begin
        if (imem_req_valid && imem_req_ready) begin
            mreq.addr = imem_req_addr;
            mreq.due  = cyc + lat;
            mq.push_back(mreq);
            acc_cnt++;
        end
    end

    initial begin
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
        cyc             = 0;
        forever begin
            @(posedge clk);
            #2;
            cyc++;
            if (!reset) begin
                // Junk response during reset must be ignored entirely.
                mq.delete();
                imem_resp_valid = 1'b1;
                imem_resp_data  = 32'hDEAD_BEEF;
            end else if (mq.size() != 0 && mq[0].due <= cyc) begin
                imem_resp_valid = 1'b1;
                imem_resp_data  = mk(mq[0].addr);
                void'(mq.pop_front());
            end else begin
                imem_resp_valid = 1'b0;
                imem_resp_data  = '0;
            end
        end
    end

    // Scoreboard monitor: every dequeue must match the next expected delivery.
    always @(negedge clk) begin
        if (reset && if_valid && !stall && !redirect) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL deliver: got pc+4 %0h instr %0h, required no delivery",
                         if_pc_plus4, if_instruction);
            end else begin
                mon_exp = exp_q.pop_front();
                chk("deliver", {if_pc_plus4, if_instruction}, mon_exp);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, required $finish");
        $fatal(1);
    end

    initial begin
        errors         = 0;
        checks         = 0;
        acc_cnt        = 0;
        lat            = 1;
        reset          = 1'b0;
        imem_req_ready = 1'b1;
        stall          = 1'b0;
        redirect       = 1'b0;
        redirect_pc    = '0;

        repeat (3) tick();
        @(negedge clk);
        chk("rst_req_valid", 64'(imem_req_valid), 64'd0);
        chk("rst_if_valid", 64'(if_valid), 64'd0);

        // Streaming from reset.
        exp_push(32'h4, 32'h0000_C0DE);
        exp_push(32'h8, 32'h0004_C0DE);
        exp_push(32'hC, 32'h0008_C0DE);
        exp_push(32'h10, 32'h000C_C0DE);
        tick();
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("stream_req_valid", 64'(imem_req_valid), 64'd1);
            chk("stream_addr", 64'(imem_req_addr), 64'(4 * i));
            if (i >= 2) chk("stream_if_valid", 64'(if_valid), 64'd1);
            tick();
        end
        imem_req_ready = 1'b0;
        @(negedge clk);
        chk("stream_if_valid", 64'(if_valid), 64'd1);
        tick();
        @(negedge clk);
        chk("stream_if_valid", 64'(if_valid), 64'd1);
        tick();

        // Backpressure: address held, nothing allocated.
        acc_base = acc_cnt;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_if_valid", 64'(if_valid), 64'd0);
            chk("bp_req_valid", 64'(imem_req_valid), 64'd1);
            chk("bp_addr", 64'(imem_req_addr), 64'h10);
            tick();
        end
        chk("bp_no_accept", 64'(acc_cnt - acc_base), 64'd0);

        // Buffer full under stall.
        stall          = 1'b1;
        imem_req_ready = 1'b1;
        acc_base       = acc_cnt;
        exp_push(32'h14, 32'h0010_C0DE);
        exp_push(32'h18, 32'h0014_C0DE);
        exp_push(32'h1C, 32'h0018_C0DE);
        exp_push(32'h20, 32'h001C_C0DE);
        repeat (10) tick();
        @(negedge clk);
        chk("full_req_count", 64'(acc_cnt - acc_base), 64'd4);
        chk("full_req_valid", 64'(imem_req_valid), 64'd0);
        chk("full_if_valid", 64'(if_valid), 64'd1);
        tick();
        stall          = 1'b0;
        imem_req_ready = 1'b0;
        @(negedge clk);
        chk("full_resume_addr", 64'(imem_req_addr), 64'h20);
        repeat (5) tick();
        @(negedge clk);
        chk("full_drained", 64'(if_valid), 64'd0);

        // Redirect with two responses in flight.
        tick();
        lat            = 3;
        imem_req_ready = 1'b1;
        tick();
        tick();
        imem_req_ready = 1'b0;
        redirect       = 1'b1;
        redirect_pc    = 32'h0000_0103;
        @(negedge clk);
        chk("redir_req_valid", 64'(imem_req_valid), 64'd0);
        tick();
        redirect       = 1'b0;
        imem_req_ready = 1'b1;
        lat            = 1;
        exp_push(32'h104, 32'h0100_C0DE);
        @(negedge clk);
        chk("redir_if_valid", 64'(if_valid), 64'd0);
        chk("redir_addr", 64'(imem_req_addr), 64'h100);
        chk("redir_req_valid2", 64'(imem_req_valid), 64'd1);
        tick();
        imem_req_ready = 1'b0;
        @(negedge clk);
        chk("redir_drop_late", 64'(if_valid), 64'd0);
        repeat (4) tick();

        // Redirect while stalled with full entries.
        stall          = 1'b1;
        imem_req_ready = 1'b1;
        tick();
        tick();
        imem_req_ready = 1'b0;
        tick();
        tick();
        @(negedge clk);
        chk("stallred_held", 64'(if_valid), 64'd1);
        tick();
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0200;
        @(negedge clk);
        chk("stallred_req_valid", 64'(imem_req_valid), 64'd0);
        tick();
        redirect       = 1'b0;
        stall          = 1'b0;
        imem_req_ready = 1'b1;
        exp_push(32'h204, 32'h0200_C0DE);
        @(negedge clk);
        chk("stallred_if_valid", 64'(if_valid), 64'd0);
        chk("stallred_addr", 64'(imem_req_addr), 64'h200);
        chk("stallred_req_valid2", 64'(imem_req_valid), 64'd1);
        tick();
        imem_req_ready = 1'b0;
        repeat (3) tick();

        // Address wrap; low redirect bits ignored.
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFE;
        tick();
        redirect       = 1'b0;
        imem_req_ready = 1'b1;
        exp_push(32'h0000_0000, 32'hFFFC_C0DE);
        @(negedge clk);
        chk("wrap_addr_top", 64'(imem_req_addr), 64'hFFFF_FFFC);
        tick();
        imem_req_ready = 1'b0;
        @(negedge clk);
        chk("wrap_addr_zero", 64'(imem_req_addr), 64'h0);
        repeat (3) tick();

        // Reset with three full entries.
        stall          = 1'b1;
        imem_req_ready = 1'b1;
        repeat (3) tick();
        imem_req_ready = 1'b0;
        repeat (2) tick();
        @(negedge clk);
        chk("midrst_pre_if_valid", 64'(if_valid), 64'd1);
        chk("midrst_pre_addr", 64'(imem_req_addr), 64'hC);
        tick();
        reset = 1'b0;
        @(negedge clk);
        chk("midrst_req_valid", 64'(imem_req_valid), 64'd0);
        chk("midrst_if_valid", 64'(if_valid), 64'd0);
        tick();
        tick();
        reset          = 1'b1;
        stall          = 1'b0;
        imem_req_ready = 1'b1;
        exp_push(32'h4, 32'h0000_C0DE);
        @(negedge clk);
        chk("postrst_req_valid", 64'(imem_req_valid), 64'd1);
        chk("postrst_addr", 64'(imem_req_addr), 64'h0);
        chk("postrst_if_valid", 64'(if_valid), 64'd0);
        tick();
        imem_req_ready = 1'b0;
        repeat (4) tick();

        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
